// File: rtl/digit_serial_alu_pkg.sv
// Shared opcode and FSM definitions for the digit-serial ALU.
// Helper functions classify commands for the slice and the top.
package alu_defs;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_sub(input logic [2:0] c);
    return (c == ALU_SUB) || (c == ALU_SLT);
  endfunction

  function automatic logic is_arith(input logic [2:0] c);
    return (c == ALU_ADD) || is_sub(c);
  endfunction

endpackage

// File: rtl/digit_serial_alu_digit.sv
// One DIGIT-wide combinational ALU slice built from 1-bit cells.
// Exposes the carry into its top bit for overflow detection.
module alu_digit
  import alu_defs::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             carryin,
  input  logic [2:0]       command,
  output logic [DIGIT-1:0] result,
  output logic             carryout,
  output logic             carrymsb
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] s;
  logic             c;

  // Ripple the carry through DIGIT full-adder cells, then pick the op.
  always_comb begin
    bx       = b ^ {DIGIT{is_sub(command)}};
    s        = '0;
    c        = carryin;
    carrymsb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) carrymsb = c;
      s[i] = a[i] ^ bx[i] ^ c;
      c    = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    carryout = c;
    unique case (1'b1)
      is_arith(command):    result = s;
      command == ALU_XOR:   result = a ^ b;
      command == ALU_AND:   result = a & b;
      command == ALU_NAND:  result = ~(a & b);
      command == ALU_NOR:   result = ~(a | b);
      command == ALU_OR:    result = a | b;
      default:              result = s;
    endcase
  end

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: WIDTH/DIGIT cycles per op, LSB digit first.
// Define ALU_OPCOUNT_EN to add the op_count completed-op counter.
module digit_serial_alu
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
`ifdef ALU_OPCOUNT_EN
  output logic             zero,
  output logic [15:0]      op_count
`else
  output logic             zero
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [2:0]       cmd;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] d;
  logic             dco;
  logic             dcm;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] fin;
  logic             ovf;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sr[DIGIT-1:0]),
    .b        (b_sr[DIGIT-1:0]),
    .carryin  (carry),
    .command  (cmd),
    .result   (d),
    .carryout (dco),
    .carrymsb (dcm)
  );

  // Next result shift value and the final result/overflow on the last digit.
  always_comb begin
    nxt = (res_sr >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
    ovf = dcm ^ dco;
    fin = (cmd == ALU_SLT) ? WIDTH'(d[DIGIT-1] ^ ovf) : nxt;
  end

  // Handshake FSM, operand/result shifting and flag capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cmd       <= ALU_ADD;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= operandA;
            b_sr     <= operandB;
            cmd      <= command;
            res_sr   <= '0;
            carry    <= is_sub(command);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= nxt;
          carry  <= dco;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(NDIG - 1)) begin
            result    <= fin;
            zero      <= (fin == '0);
            carryout  <= is_arith(cmd) ? dco : 1'b0;
            overflow  <= is_arith(cmd) ? ovf : 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_OPCOUNT_EN
  // Count results accepted by the consumer; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) op_count <= '0;
    else if (out_valid && out_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule
